// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: walks one low column at a time, debounces the
// first row seen low and reports a single key code per press.
module keypad_scanner #(
   parameter int SCAN_EXP       = 16,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] keypad_row,
   output logic [3:0] keypad_col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2
   } state_t;

   localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_TICKS);

   logic [3:0]          row_meta_r;
   logic [3:0]          row_sync_r;
   logic [SCAN_EXP-1:0] presc_r;
   logic                tick_s;
   logic                row_bit_s;

   state_t     state_r, state_nx_s;
   logic [1:0] col_idx_r, col_idx_nx_s;
   logic [1:0] row_idx_r, row_idx_nx_s;
   logic [3:0] cnt_r, cnt_nx_s;
   logic [3:0] key_code_r, key_code_nx_s;
   logic       key_valid_r, key_valid_nx_s;
   logic       key_held_r, key_held_nx_s;
   logic [3:0] keypad_col_r;

   // Lowest-numbered row that reads low wins when several are pressed.
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      logic [1:0] idx;
      if (!rows[0])      idx = 2'd0;
      else if (!rows[1]) idx = 2'd1;
      else if (!rows[2]) idx = 2'd2;
      else               idx = 2'd3;
      return idx;
   endfunction

   assign tick_s    = &presc_r;
   assign row_bit_s = row_sync_r[row_idx_r];

   // Two-flop row synchroniser and free-running tick prescaler.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta_r <= 4'hF;
         row_sync_r <= 4'hF;
         presc_r    <= '0;
      end else begin
         row_meta_r <= keypad_row;
         row_sync_r <= row_meta_r;
         presc_r    <= presc_r + {{(SCAN_EXP-1){1'b0}}, 1'b1};
      end
   end

   // Scan / debounce / hold decisions, evaluated only on a tick.
   always_comb begin
      state_nx_s     = state_r;
      col_idx_nx_s   = col_idx_r;
      row_idx_nx_s   = row_idx_r;
      cnt_nx_s       = cnt_r;
      key_code_nx_s  = key_code_r;
      key_valid_nx_s = 1'b0;
      key_held_nx_s  = key_held_r;
      if (tick_s) begin
         case (state_r)
            SCAN: begin
               if (row_sync_r != 4'hF) begin
                  row_idx_nx_s = lowest_low(row_sync_r);
                  cnt_nx_s     = 4'd1;
                  state_nx_s   = DEBOUNCE;
               end else begin
                  col_idx_nx_s = col_idx_r + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (!row_bit_s) begin
                  if (cnt_r + 4'd1 >= DB_LIM) begin
                     state_nx_s     = PRESSED;
                     key_code_nx_s  = {row_idx_r, col_idx_r};
                     key_valid_nx_s = 1'b1;
                     key_held_nx_s  = 1'b1;
                     cnt_nx_s       = 4'd0;
                  end else begin
                     cnt_nx_s = cnt_r + 4'd1;
                  end
               end else begin
                  state_nx_s   = SCAN;
                  col_idx_nx_s = col_idx_r + 2'd1;
                  cnt_nx_s     = 4'd0;
               end
            end
            PRESSED: begin
               // cnt_r now counts consecutive released ticks.
               if (row_bit_s) begin
                  if (cnt_r + 4'd1 >= DB_LIM) begin
                     state_nx_s    = SCAN;
                     key_held_nx_s = 1'b0;
                     col_idx_nx_s  = col_idx_r + 2'd1;
                     cnt_nx_s      = 4'd0;
                  end else begin
                     cnt_nx_s = cnt_r + 4'd1;
                  end
               end else begin
                  cnt_nx_s = 4'd0;
               end
            end
            default: begin
               state_nx_s    = SCAN;
               cnt_nx_s      = 4'd0;
               key_held_nx_s = 1'b0;
            end
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // State and registered outputs; column drive follows the next column index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= SCAN;
         col_idx_r    <= 2'd0;
         row_idx_r    <= 2'd0;
         cnt_r        <= 4'd0;
         key_code_r   <= 4'd0;
         key_valid_r  <= 1'b0;
         key_held_r   <= 1'b0;
         keypad_col_r <= 4'b1110;
      end else begin
         state_r      <= state_nx_s;
         col_idx_r    <= col_idx_nx_s;
         row_idx_r    <= row_idx_nx_s;
         cnt_r        <= cnt_nx_s;
         key_code_r   <= key_code_nx_s;
         key_valid_r  <= key_valid_nx_s;
         key_held_r   <= key_held_nx_s;
         keypad_col_r <= ~(4'b0001 << col_idx_nx_s);
      end
   end

   assign keypad_col = keypad_col_r;
   assign key_code   = key_code_r;
   assign key_valid  = key_valid_r;
   assign key_held   = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, timed hand sequences,
// a vector table and randomized presses checked against press-level rules.
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] keypad_row;
   logic [3:0] keypad_col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys_pressed;
   int          pass_cnt;
   int          total_cnt;
   int          cur_k;
   int          valid_cnt;
   int          width_err;
   logic        prev_valid;

   keypad_scanner #(.SCAN_EXP(2), .DEBOUNCE_TICKS(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .keypad_row (keypad_row),
      .keypad_col (keypad_col),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_held   (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Membrane matrix: a pressed key shorts its row to its column when that column is low.
   always_comb begin
      keypad_row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys_pressed[r*4+c] && !keypad_col[c]) keypad_row[r] = 1'b0;
   end

   // Count key_valid pulses, remember their codes, flag pulses wider than one clk.
   always @(negedge clk) begin
      if (reset && key_valid) begin
         valid_cnt <= valid_cnt + 1;
         if (prev_valid) width_err <= width_err + 1;
      end
      prev_valid <= key_valid;
   end

   typedef struct {
      logic [15:0] keys;
      int          hold;
      logic        exp_valid;
      logic [3:0]  exp_code;
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      total_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      cur_k = 0;
   endtask

   task automatic go_to(input int k);
      while (cur_k < k) begin
         @(negedge clk);
         cur_k++;
      end
   endtask

   // One press: expect exactly one pulse with the given code for a long press, none for a bounce.
   task automatic run_txn(input string name, input logic [15:0] keys, input int hold,
                          input logic exp_valid, input logic [3:0] exp_code);
      int base;
      base = valid_cnt;
      keys_pressed = keys;
      repeat (hold) @(negedge clk);
      if (exp_valid) check({name, "_held_on"}, key_held, 1);
      keys_pressed = 16'h0000;
      repeat (50) @(negedge clk);
      check({name, "_pulses"}, valid_cnt - base, exp_valid ? 1 : 0);
      if (exp_valid) check({name, "_code"}, key_code, exp_code);
      check({name, "_held_off"}, key_held, 0);
   endtask

   initial begin
      vec_t        vecs[8];
      logic [3:0]  exp_col;
      logic [15:0] one;
      int          base;

      pass_cnt = 0; total_cnt = 0; valid_cnt = 0; width_err = 0;
      prev_valid = 1'b0; cur_k = 0;
      keys_pressed = 16'h0000;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_col", keypad_col, 4'b1110);
      check("reset_code", key_code, 0);
      check("reset_valid", key_valid, 0);
      check("reset_held", key_held, 0);

      // Idle scanning walks the columns, 4 clk per column.
      do_reset();
      base = valid_cnt;
      for (int k = 0; k < 20; k++) begin
         go_to(k);
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         check($sformatf("idle_col_k%0d", k), keypad_col, exp_col);
      end
      check("idle_no_valid", valid_cnt - base, 0);

      // Key 6 held: pulse exactly 3 ticks after detection, release 3 ticks after letting go.
      do_reset();
      base = valid_cnt;
      go_to(8);  keys_pressed = 16'h0040;
      go_to(19); check("k6_no_early_valid", valid_cnt - base, 0);
                 check("k6_col_held", keypad_col, 4'b1011);
      go_to(20); check("k6_valid", key_valid, 1);
                 check("k6_code", key_code, 6);
                 check("k6_held", key_held, 1);
      go_to(21); check("k6_valid_1clk", key_valid, 0);
      go_to(88); keys_pressed = 16'h0000;
      go_to(99); check("k6_held_before_rel", key_held, 1);
      go_to(100); check("k6_held_fall", key_held, 0);
                  check("k6_col_after_rel", keypad_col, 4'b0111);
                  check("k6_code_kept", key_code, 6);
                  check("k6_one_pulse", valid_cnt - base, 1);

      // Bounce: key 6 low for only two ticks.
      do_reset();
      base = valid_cnt;
      go_to(8);  keys_pressed = 16'h0040;
      go_to(16); keys_pressed = 16'h0000;
      go_to(19); check("bounce_col_held", keypad_col, 4'b1011);
      go_to(20); check("bounce_resume_col3", keypad_col, 4'b0111);
      go_to(40); check("bounce_no_valid", valid_cnt - base, 0);

      // Reset mid-debounce with the key still held.
      do_reset();
      base = valid_cnt;
      go_to(8);  keys_pressed = 16'h0040;
      go_to(14);
      reset = 1'b0;
      #1;
      check("rst_mid_col", keypad_col, 4'b1110);
      check("rst_mid_valid", key_valid, 0);
      check("rst_mid_held", key_held, 0);
      check("rst_mid_code", key_code, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cur_k = 0;
      go_to(19); check("rst_mid_no_early", valid_cnt - base, 0);
      go_to(20); check("rst_mid_valid_again", key_valid, 1);
                 check("rst_mid_code_again", key_code, 6);
      keys_pressed = 16'h0000;
      go_to(60);

      // Key 6 held while key 15 comes and goes: first key wins, no second pulse.
      base = valid_cnt;
      keys_pressed = 16'h0040;
      repeat (60) @(negedge clk);
      check("roll_first_pulse", valid_cnt - base, 1);
      keys_pressed = 16'h8040;
      repeat (40) @(negedge clk);
      keys_pressed = 16'h0040;
      repeat (40) @(negedge clk);
      check("roll_still_held", key_held, 1);
      keys_pressed = 16'h0000;
      repeat (60) @(negedge clk);
      check("roll_no_second", valid_cnt - base, 1);
      check("roll_code", key_code, 6);
      check("roll_released", key_held, 0);

      vecs[0] = '{16'h0040, 60, 1'b1, 4'd6};
      vecs[1] = '{16'h0040,  6, 1'b0, 4'd0};
      vecs[2] = '{16'h2002, 60, 1'b1, 4'd1};
      vecs[3] = '{16'h8000, 60, 1'b1, 4'd15};
      vecs[4] = '{16'h0001, 60, 1'b1, 4'd0};
      vecs[5] = '{16'h0400,  8, 1'b0, 4'd0};
      vecs[6] = '{16'h1111, 70, 1'b1, 4'd0};
      vecs[7] = '{16'h8800, 60, 1'b1, 4'd11};
      for (int i = 0; i < 8; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].keys, vecs[i].hold,
                 vecs[i].exp_valid, vecs[i].exp_code);

      // Random presses in one column (one or two rows), long or bouncing.
      one = 16'h0001;
      for (int i = 0; i < 30; i++) begin
         int col, r1, r2, hold;
         logic longp;
         col   = int'($urandom_range(3));
         r1    = int'($urandom_range(3));
         r2    = ($urandom_range(1) == 1) ? int'($urandom_range(3)) : r1;
         longp = ($urandom_range(1) == 1);
         hold  = longp ? int'($urandom_range(120, 60)) : int'($urandom_range(8, 1));
         run_txn($sformatf("rnd%0d", i),
                 (one << (r1*4 + col)) | (one << (r2*4 + col)), hold, longp,
                 4'(((r1 < r2) ? r1 : r2) * 4 + col));
      end

      check("valid_pulse_width", width_err, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 membrane keypad through the board's matrix connector. It drives one column line low at a time, reads the four row lines, debounces the result and reports a single 4-bit key code per press. This is the input-side counterpart of the 8x8 LED matrix driver, and it feeds key codes to top-level control logic such as colour select and scroll control.

Parameters:
SCAN_EXP, 16, scan tick period is 2^SCAN_EXP clk cycles; minimum 2.
DEBOUNCE_TICKS, 4, consecutive scan ticks of stable level needed to confirm a press or a release; minimum 1, at most 15.

Ports:
clk  input  1  system clock; the only clock in the block.
reset  input  1  asynchronous, active-low reset.
keypad_row  input  4  row sense lines; active-low with external pull-ups; bit i is row i.
keypad_col  output  4  column drive; exactly one bit is low, the others are high.
key_code  output  4  code of the last confirmed key, equal to row*4+col; holds its value between presses.
key_valid  output  1  one-clk pulse when a new key_code is presented.
key_held  output  1  high while the confirmed key remains pressed.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=SCAN, column index=0, keypad_col=4'b1110.
  - key_code=0, key_valid=0, key_held=0.
  - Synchroniser flops=4'hF; prescaler and debounce counter=0.
  - Reset may be asserted in any state and aborts the operation in progress. No key_valid is issued for the aborted press.
- Synchroniser: keypad_row passes through two flops before use (row_s). All decisions use row_s only.
- Tick: free-running SCAN_EXP-bit prescaler. tick=1 for one clk when the prescaler is all-ones. All state and column changes happen only on tick.
- Column drive: keypad_col = ~(4'b0001 << col_idx), registered. A column is held for a full tick period before it is sampled, which covers the 2-cycle synchroniser delay.
- State SCAN, on tick:
  - If row_s != 4'hF: latch row_idx (lowest-numbered low bit) and col_idx, set the debounce count to 1, go to DEBOUNCE, and keep the column.
  - Otherwise advance col_idx (3 wraps to 0).
- State DEBOUNCE, on tick:
  - If row_s[row_idx]==0: increment the count.
  - When the count reaches DEBOUNCE_TICKS: go to PRESSED, load key_code={row_idx,col_idx}, pulse key_valid for exactly the next clk, set key_held=1.
  - If row_s[row_idx]==1: return to SCAN and advance col_idx. No output change.
  - With DEBOUNCE_TICKS=1, the DEBOUNCE state is passed through on the next tick whenever the row is still low.
- State PRESSED: column is held and key_held=1. On tick:
  - If row_s[row_idx]==1: increment the release count.
  - If row_s[row_idx]==0: clear the release count.
  - When the release count reaches DEBOUNCE_TICKS: key_held=0, go to SCAN, advance col_idx.
- Other keys pressed during DEBOUNCE or PRESSED are ignored, including other rows in the same column. This gives rollover-free, first-key-wins behaviour.
- Multiple rows low at detection: the lowest row index wins.
- key_valid is never high for more than 1 clk and never reasserts without an intervening release.
- Nominal latency from a clean press to key_valid: at most (4 + DEBOUNCE_TICKS) ticks plus 3 clk.

Test Plan:
Simulation parameters for all scenarios: SCAN_EXP=2, DEBOUNCE_TICKS=3.
1. Reset, then hold reset=1 with no keys -> keypad_col cycles 1110,1101,1011,0111,1110 with 4 clk per step; key_valid stays 0.
2. Hold row1 low only while col2 is low (key 6) for 20 ticks -> one key_valid pulse, key_code=4'd6, key_held=1. After release, key_held falls 3 ticks later.
3. Row1 low for 2 ticks only at col2 (bounce) -> no key_valid; scanning resumes at col3.
4. Rows 0 and 3 low together at col1 -> key_code=4'd1 (row 0 wins), single pulse.
5. Key 6 held, key 15 pressed and released, then key 6 released -> no second key_valid; key_code stays 6.
6. Assert reset mid-DEBOUNCE -> all outputs go immediately to their reset values (keypad_col=1110); no key_valid after reset is released while the key is still held until a full debounce completes again.
